// File: rtl/imem_load_ctrl_if.sv
// Bundle of loader, CPU-fetch, memory and status signals for imem_load_ctrl.
// The slave modport is the controller's view; the master modport is its environment.
interface imem_load_ctrl_if #(
    parameter int ADDR_LEN   = 32,
    parameter int INSTR_LEN  = 32,
    parameter int IMEM_DEPTH = 1024
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic                 ld_valid;
    logic [7:0]           ld_byte;
    logic                 ld_last;
    logic                 ld_ready;
    logic                 restart;
    logic [ADDR_LEN-1:0]  cpu_pc;
    logic [INSTR_LEN-1:0] cpu_instr;
    logic                 cpu_stall;
    logic [AW-1:0]        mem_addr;
    logic [INSTR_LEN-1:0] mem_wdata;
    logic                 mem_we;
    logic [INSTR_LEN-1:0] mem_rdata;
    logic                 load_done;
    logic                 load_err;
    logic [AW:0]          load_words;

    modport slave (
        input  ld_valid, ld_byte, ld_last, restart, cpu_pc, mem_rdata,
        output ld_ready, cpu_instr, cpu_stall, mem_addr, mem_wdata, mem_we,
               load_done, load_err, load_words
    );

    modport master (
        output ld_valid, ld_byte, ld_last, restart, cpu_pc, mem_rdata,
        input  ld_ready, cpu_instr, cpu_stall, mem_addr, mem_wdata, mem_we,
               load_done, load_err, load_words
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory loader: packs a byte stream into little-endian words, writes them
// to memory, then hands the memory to the CPU fetch port until a restart.
module imem_load_ctrl #(
    parameter int ADDR_LEN   = 32,
    parameter int INSTR_LEN  = 32,
    parameter int IMEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_load_ctrl_if.slave   bus
);
    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StWrite = 2'd1,
        StRun   = 2'd2,
        StErr   = 2'd3
    } state_t;

    state_t               r_state, w_state;
    logic [1:0]           r_byte_idx, w_byte_idx;
    logic [INSTR_LEN-1:0] r_asm, w_asm;
    logic                 r_last, w_last;
    logic [AW:0]          r_words, w_words;
    logic                 r_err, w_err;

    logic                 w_accept;
    logic                 w_full;
    logic                 w_pc_hi;

    assign w_accept = bus.ld_valid && (r_state == StLoad);
    assign w_full   = (r_words == (AW+1)'(IMEM_DEPTH));
    assign w_pc_hi  = ((bus.cpu_pc >> (AW + 2)) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StLoad;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_last     <= 1'b0;
            r_words    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_byte_idx <= w_byte_idx;
            r_asm      <= w_asm;
            r_last     <= w_last;
            r_words    <= w_words;
            r_err      <= w_err;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_byte_idx = r_byte_idx;
        w_asm      = r_asm;
        w_last     = r_last;
        w_words    = r_words;
        w_err      = r_err;

        unique case (r_state)
            StLoad: begin
                if (w_accept) begin
                    if (w_full) begin
                        w_state = StErr;
                        w_err   = 1'b1;
                    end else begin
                        w_asm[int'(r_byte_idx)*8 +: 8] = bus.ld_byte;
                        w_last                         = bus.ld_last;
                        if (r_byte_idx == 2'd3 || bus.ld_last) begin
                            w_state = StWrite;
                        end else begin
                            w_byte_idx = r_byte_idx + 2'd1;
                        end
                    end
                end
            end
            StWrite: begin
                w_words    = r_words + (AW+1)'(1);
                w_byte_idx = '0;
                w_asm      = '0;
                w_state    = r_last ? StRun : StLoad;
            end
            StRun: ;
            StErr: ;
            default: w_state = StLoad;
        endcase

        // Restart wins everywhere; the WRITE-cycle strobe is decoded from r_state, so it still fires.
        if (bus.restart) begin
            w_state    = StLoad;
            w_byte_idx = '0;
            w_asm      = '0;
            w_last     = 1'b0;
            w_words    = '0;
            w_err      = 1'b0;
        end
    end

    assign bus.ld_ready   = (r_state == StLoad);
    assign bus.mem_we     = (r_state == StWrite);
    assign bus.cpu_stall  = (r_state != StRun);
    assign bus.load_done  = (r_state == StRun);
    assign bus.load_err   = r_err;
    assign bus.load_words = r_words;
    assign bus.mem_wdata  = r_asm;
    assign bus.mem_addr   = (r_state == StRun) ? bus.cpu_pc[AW+1:2] : r_words[AW-1:0];
    assign bus.cpu_instr  = ((r_state == StRun) && !w_pc_hi) ? bus.mem_rdata : '0;
endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter ADDR_LEN, default 32, width of CPU fetch address.
REQ-002 Parameter INSTR_LEN, default 32, instruction word width.
REQ-003 Parameter IMEM_DEPTH, default 1024, instruction memory depth in words; the word-address width AW SHALL be log2(IMEM_DEPTH), which is 10 at the default.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 ld_valid  input  1  loader byte valid.
REQ-007 ld_byte  input  8  loader program byte.
REQ-008 ld_last  input  1  marks the final byte of the program; qualified by ld_valid.
REQ-009 ld_ready  output  1  controller can accept a loader byte.
REQ-010 restart  input  1  request to re-enter load mode.
REQ-011 cpu_pc  input  ADDR_LEN  CPU fetch byte address.
REQ-012 cpu_instr  output  INSTR_LEN  fetched instruction.
REQ-013 cpu_stall  output  1  holds the CPU while the program is not loaded.
REQ-014 mem_addr  output  AW  memory word address.
REQ-015 mem_wdata  output  INSTR_LEN  memory write data.
REQ-016 mem_we  output  1  memory write enable; the write SHALL take effect on a clk rising edge.
REQ-017 mem_rdata  input  INSTR_LEN  combinational memory read data at mem_addr.
REQ-018 load_done  output  1  program loaded, CPU running.
REQ-019 load_err  output  1  program exceeded IMEM_DEPTH words.
REQ-020 load_words  output  AW+1  number of words written since the last entry to LOAD.

Function
REQ-021 FSM states SHALL be LOAD, WRITE, RUN and ERR, with registered state.
REQ-022 LOAD: ld_ready=1; a byte is accepted when ld_valid&&ld_ready, and it SHALL be stored little-endian at lane byte_idx (byte 0 in [7:0]).
REQ-023 LOAD: the controller SHALL go to WRITE on acceptance when byte_idx==3 or ld_last=1; otherwise byte_idx increments and the state stays LOAD.
REQ-024 LOAD: ld_last SHALL be captured into a last flag at acceptance.
REQ-025 WRITE (one cycle): ld_ready=0, mem_we=1, mem_addr=load_words[AW-1:0], mem_wdata=assembled word with unfilled lanes zero.
REQ-026 WRITE exit: load_words increments, byte_idx and the assembly register clear, and the next state SHALL be RUN if the last flag is set, else LOAD.
REQ-027 Overflow: a byte accepted in LOAD while load_words==IMEM_DEPTH SHALL be discarded, with next state ERR and load_err=1.
REQ-028 RUN: cpu_stall=0, load_done=1, ld_ready=0, mem_we=0, mem_addr=cpu_pc[AW+1:2].
REQ-029 RUN: cpu_instr=mem_rdata combinationally (zero latency), except when cpu_pc[ADDR_LEN-1:AW+2]!=0, where cpu_instr=0 (nop).
REQ-030 Non-RUN states: cpu_stall=1, cpu_instr=0, load_done=0.
REQ-031 ERR: ld_ready=0, mem_we=0, load_err=1; the controller SHALL hold there until restart.
REQ-032 restart=1 in any state SHALL force the next state to LOAD and clear byte_idx, the assembly register, the last flag, load_words and load_err.
REQ-033 If restart=1 in WRITE, that cycle's write SHALL still occur.
REQ-034 In LOAD, restart SHALL take priority over a simultaneously accepted byte, and that byte is dropped.
REQ-035 ld_last with a partial word SHALL write the zero-padded word and then enter RUN.
REQ-036 In non-LOAD states, input bytes SHALL be ignored (ld_ready=0).

Reset
REQ-037 While rst_n=0: state=LOAD, byte_idx=0, assembly register=0, last flag=0, load_words=0, load_err=0.
REQ-038 While rst_n=0 outputs: ld_ready=1, cpu_stall=1, cpu_instr=0, mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, load_err=0.
REQ-039 Reset assertion mid-WRITE SHALL suppress mem_we immediately (asynchronously).
REQ-040 Deassertion SHALL be sampled on clk, and the first accept SHALL be possible on the first edge after deassertion.

Verification
REQ-041 Bytes 13,00,10,00 (last on 4th) -> WRITE addr 0 data 0x00100013; then RUN, load_done=1, load_words=1.
REQ-042 8 bytes, then cpu_pc=0x4 -> cpu_instr equals the second word the same cycle; cpu_pc=0x1000 -> cpu_instr=0.
REQ-043 Bytes AA,BB with last on BB -> mem_wdata=0x0000BBAA written at addr 0, then RUN.
REQ-044 IMEM_DEPTH=4: 17 bytes without last -> 4 writes, then 17th byte -> ERR, load_err=1, cpu_stall=1; restart -> LOAD with load_words=0.
REQ-045 restart pulse in RUN -> next cycle cpu_stall=1, ld_ready=1; reload of 4 bytes overwrites addr 0.
REQ-046 rst_n low during WRITE -> mem_we drops the same cycle; after release state=LOAD, load_words=0.
